ifmap_spad_writer: RTL and testbench
====================================

# ifmap_spad_writer

Write-side controller for the PE's circular ifmap scratchpad, the producer counterpart of the ifmap read-address generator. It accepts ifmap elements over a valid/ready handshake, writes them at a wrapping write pointer and tracks occupancy against releases from the read side. It raises `window_ready` once a full filter window is resident, and stalls the producer when the spad is full.

## Interface
- `CONFIG_BIT`, 5, width of size configuration inputs
- `IFMAP_SPAD_ADDRESS_WIDTH`, 16, spad address width
- `IFMAP_SPAD_DEPTH`, 12, spad entries; pointer wraps at this value
- `DATA_WIDTH`, 16, ifmap element width

Ports:
- `clk` in 1: single clock, rising edge
- `rstn` in 1: asynchronous, active-low reset
- `filter_size` in CONFIG_BIT: filter row length; sampled on `start`
- `ifmap_size` in CONFIG_BIT: ifmap row length (elements to write); sampled on `start`
- `start` in 1: one-cycle pulse, begins a row
- `if_clear` in 1: synchronous flush
- `in_valid` in 1: producer element valid
- `in_data` in DATA_WIDTH: producer element
- `in_ready` out 1: writer can accept
- `release` in 1: read side slid window by one; frees oldest entry
- `spad_wen` out 1: spad write enable
- `spad_waddr` out IFMAP_SPAD_ADDRESS_WIDTH: spad write address
- `spad_wdata` out DATA_WIDTH: spad write data
- `count` out $clog2(IFMAP_SPAD_DEPTH+1): resident entries
- `window_ready` out 1: `count >= filter_size`
- `full` out 1: `count == IFMAP_SPAD_DEPTH`
- `row_done` out 1: one-cycle pulse, all `ifmap_size` elements written

## Operation
- FSM states: IDLE, FILL, DONE.
- IDLE: `in_ready` = 0. On `start`, load the size registers, clear `written`, and go to FILL. Pointer and count are kept, so rows can chain.
- FILL: `in_ready` = !full. A handshake is `in_valid & in_ready`. On a handshake, write `in_data` at `wptr`, advance `wptr` (DEPTH-1 wraps to 0), increment `written`. When the handshake makes `written == ifmap_size`, pulse `row_done` and go to DONE.
- DONE: `in_ready` = 0. Releases continue to drain `count`. Return to IDLE when `count == 0`.
- Occupancy:
  - handshake only: +1
  - release only: -1
  - both in the same cycle: unchanged, pointer still advances
- `release` with `count == 0` is ignored; count never underflows.
- `full` gates `in_ready` combinationally, so a write is never accepted at full. A release in the same cycle does not unblock `in_ready` until the next cycle.
- `if_clear` has priority over everything:
  - `wptr`, `count` and `written` go to 0, state goes to IDLE
  - no write is issued that cycle
  - overrides a coincident `start`
- `start` outside IDLE is ignored.
- `ifmap_size == 0` at `start`: go directly to DONE with a `row_done` pulse next cycle.

## Timing
- Reset values: `in_ready` 0, `spad_wen` 0, `spad_waddr` 0, `spad_wdata` 0, `count` 0, `window_ready` 0, `full` 0, `row_done` 0, state IDLE.
- `spad_wen`/`spad_waddr`/`spad_wdata` are registered: asserted the cycle after the handshake, holding that handshake's address and data.
- `count`, `full` and `window_ready` update on the handshake/release edge (registered count, combinational compares).
- `row_done` is registered: high the cycle after the last handshake.
- Throughput: one element per cycle while not full.

## Configuration
- `IFMAP_SPAD_WR_CHECK_EN` defined: adds output `err` (1 bit, reset 0), a sticky flag cleared only by `if_clear` or reset. It sets on any of:
  - release while `count == 0`
  - `start` with `filter_size > IFMAP_SPAD_DEPTH`
  - `start` with `filter_size == 0`
- Not defined: no `err` port and no check logic; the behaviour of all other outputs is identical.

## Structure
- Shared package holds the FSM state typedef (`IDLE`/`FILL`/`DONE`) and the count-width constant function.
- One sub-module: `wrap_pointer`, a modulo-DEPTH up-counter with enable and clear, used for `wptr`.
- Occupancy and FSM stay in the top module.

## Test plan
- Reset mid-row, then check outputs → all outputs 0, state IDLE, `in_ready` 0.
- DEPTH=12, filter_size=3, ifmap_size=5, `start`, 5 back-to-back valids, no release → addresses 0..4 written one cycle after each handshake. `window_ready` rises after the 3rd handshake, `row_done` pulses after the 5th, count 5.
- 12 writes with no release, 13th held valid → `full`=1, `in_ready`=0. Then one `release` → `in_ready` returns next cycle, 13th element written at address 0 (wrap-around).
- Handshake and `release` in the same cycle at count 4 → count stays 4, `spad_waddr` advances by 1.
- `if_clear` coincident with `start` and a handshake → no write issued, count 0, state IDLE, next write address 0.
- With `IFMAP_SPAD_WR_CHECK_EN`: release at count 0 → `err`=1 and stays 1 until `if_clear`; count stays 0.

Source files
------------

// File: rtl/ifmap_spad_writer_pkg.sv
// Shared definitions for the ifmap scratchpad writer: FSM state encoding,
// default sizing and the occupancy-counter width helper.
package ifmap_spad_writer_pkg;

  localparam int unsigned DEF_CONFIG_BIT               = 5;
  localparam int unsigned DEF_IFMAP_SPAD_ADDRESS_WIDTH = 16;
  localparam int unsigned DEF_IFMAP_SPAD_DEPTH         = 12;
  localparam int unsigned DEF_DATA_WIDTH               = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t FILL = 2'd1;
  localparam state_t DONE = 2'd2;

  // Bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

endpackage

// File: rtl/ifmap_spad_writer_if.sv
// Producer-to-writer element stream (valid/ready).
//   in_valid : producer element valid
//   in_data  : producer element
//   in_ready : writer can accept this cycle
// master = producer side, slave = writer side.
import ifmap_spad_writer_pkg::*;

interface ifmap_spad_writer_if #(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/ifmap_spad_writer_wrap_pointer.sv
// wrap_pointer: modulo-DEPTH up-counter with enable and synchronous clear.
//   clk, rstn : clock, async active-low reset
//   clr       : synchronous clear to 0 (wins over en)
//   en        : advance by one, DEPTH-1 wraps to 0
//   ptr       : current pointer value (registered)
module wrap_pointer #(
  parameter int unsigned DEPTH = 12,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] ptr
);

  logic [WIDTH-1:0] ptr_q, ptr_d;

  // Next pointer value.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (en) begin
      ptr_d = (ptr_q == WIDTH'(DEPTH - 1)) ? '0 : ptr_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ifmap_spad_writer.sv
// ifmap_spad_writer: write-side controller for the PE's circular ifmap
// scratchpad. Accepts elements over a valid/ready stream, writes them at a
// wrapping pointer, tracks occupancy against read-side releases and flags
// when a full filter window is resident.
//   clk, rstn     : clock, async active-low reset
//   filter_size   : filter row length, sampled on start
//   ifmap_size    : elements to write in this row, sampled on start
//   start         : one-cycle pulse, begins a row (IDLE only)
//   if_clear      : synchronous flush of pointer, occupancy and row progress
//   in_if         : element stream (slave side)
//   rd_release    : read side slid its window by one, frees oldest entry
//   spad_wen/waddr/wdata : registered spad write port
//   count         : resident entries
//   window_ready  : a full filter window is resident
//   full          : spad holds DEPTH entries
//   row_done      : pulse, last element of the row written
//   err           : sticky misuse flag (only with IFMAP_SPAD_WR_CHECK_EN)
// Optional build macro: IFMAP_SPAD_WR_CHECK_EN.
module ifmap_spad_writer
  import ifmap_spad_writer_pkg::*;
#(
  parameter int unsigned CONFIG_BIT               = DEF_CONFIG_BIT,
  parameter int unsigned IFMAP_SPAD_ADDRESS_WIDTH = DEF_IFMAP_SPAD_ADDRESS_WIDTH,
  parameter int unsigned IFMAP_SPAD_DEPTH         = DEF_IFMAP_SPAD_DEPTH,
  parameter int unsigned DATA_WIDTH               = DEF_DATA_WIDTH,
  localparam int unsigned COUNT_W                 = count_width(IFMAP_SPAD_DEPTH)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic [CONFIG_BIT-1:0]               filter_size,
  input  logic [CONFIG_BIT-1:0]               ifmap_size,
  input  logic                                start,
  input  logic                                if_clear,
  ifmap_spad_writer_if.slave                  in_if,
  input  logic                                rd_release,
  output logic                                spad_wen,
  output logic [IFMAP_SPAD_ADDRESS_WIDTH-1:0] spad_waddr,
  output logic [DATA_WIDTH-1:0]               spad_wdata,
  output logic [COUNT_W-1:0]                  count,
  output logic                                window_ready,
  output logic                                full,
  output logic                                row_done
`ifdef IFMAP_SPAD_WR_CHECK_EN
  ,
  output logic                                err
`endif
);

  state_t                              state_q, state_d;
  logic [CONFIG_BIT-1:0]               filter_size_q, filter_size_d;
  logic [CONFIG_BIT-1:0]               ifmap_size_q, ifmap_size_d;
  logic [CONFIG_BIT-1:0]               written_q, written_d;
  logic [COUNT_W-1:0]                  count_q, count_d;
  logic                                spad_wen_q, spad_wen_d;
  logic [IFMAP_SPAD_ADDRESS_WIDTH-1:0] spad_waddr_q, spad_waddr_d;
  logic [DATA_WIDTH-1:0]               spad_wdata_q, spad_wdata_d;
  logic                                row_done_q, row_done_d;

  logic [IFMAP_SPAD_ADDRESS_WIDTH-1:0] wptr;
  logic                                full_c;
  logic                                in_ready_c;
  logic                                hs_c;
  logic                                rel_c;

  // Full is a compare on the registered count, so a same-cycle release
  // cannot reopen in_ready; a flush cycle never accepts.
  assign full_c     = (count_q == COUNT_W'(IFMAP_SPAD_DEPTH));
  assign in_ready_c = (state_q == FILL) && !full_c && !if_clear;
  assign hs_c       = in_if.in_valid && in_ready_c;
  assign rel_c      = rd_release && (count_q != '0);

  wrap_pointer #(
    .DEPTH (IFMAP_SPAD_DEPTH),
    .WIDTH (IFMAP_SPAD_ADDRESS_WIDTH)
  ) u_wptr (
    .clk  (clk),
    .rstn (rstn),
    .clr  (if_clear),
    .en   (hs_c),
    .ptr  (wptr)
  );

  // Next-state, occupancy and write-port logic.
  always_comb begin
    state_d       = state_q;
    filter_size_d = filter_size_q;
    ifmap_size_d  = ifmap_size_q;
    written_d     = written_q;
    count_d       = count_q;
    row_done_d    = 1'b0;
    spad_wen_d    = hs_c;
    spad_waddr_d  = hs_c ? wptr : spad_waddr_q;
    spad_wdata_d  = hs_c ? in_if.in_data : spad_wdata_q;

    if (if_clear) begin
      state_d   = IDLE;
      written_d = '0;
      count_d   = '0;
    end else begin
      unique case ({hs_c, rel_c})
        2'b10:   count_d = count_q + COUNT_W'(1);
        2'b01:   count_d = count_q - COUNT_W'(1);
        default: count_d = count_q;
      endcase

      unique case (state_q)
        IDLE: begin
          if (start) begin
            filter_size_d = filter_size;
            ifmap_size_d  = ifmap_size;
            written_d     = '0;
            if (ifmap_size == '0) begin
              state_d    = DONE;
              row_done_d = 1'b1;
            end else begin
              state_d = FILL;
            end
          end
        end
        FILL: begin
          if (hs_c) begin
            written_d = written_q + CONFIG_BIT'(1);
            if (written_d == ifmap_size_q) begin
              row_done_d = 1'b1;
              state_d    = DONE;
            end
          end
        end
        DONE: begin
          if (count_q == '0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      filter_size_q <= '0;
      ifmap_size_q  <= '0;
      written_q     <= '0;
      count_q       <= '0;
      spad_wen_q    <= 1'b0;
      spad_waddr_q  <= '0;
      spad_wdata_q  <= '0;
      row_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      filter_size_q <= filter_size_d;
      ifmap_size_q  <= ifmap_size_d;
      written_q     <= written_d;
      count_q       <= count_d;
      spad_wen_q    <= spad_wen_d;
      spad_waddr_q  <= spad_waddr_d;
      spad_wdata_q  <= spad_wdata_d;
      row_done_q    <= row_done_d;
    end
  end

`ifdef IFMAP_SPAD_WR_CHECK_EN
  logic err_q, err_d;

  // Sticky misuse flag: underflowing release or an unusable filter size.
  always_comb begin
    err_d = err_q;
    if (if_clear) begin
      err_d = 1'b0;
    end else if ((rd_release && (count_q == '0)) ||
                 (start && ((32'(filter_size) > IFMAP_SPAD_DEPTH) || (filter_size == '0)))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`endif

  // Window needs at least one resident entry so an unloaded size of 0
  // does not report a window out of reset.
  assign window_ready   = (count_q != '0) && (32'(count_q) >= 32'(filter_size_q));
  assign full           = full_c;
  assign count          = count_q;
  assign in_if.in_ready = in_ready_c;
  assign spad_wen       = spad_wen_q;
  assign spad_waddr     = spad_waddr_q;
  assign spad_wdata     = spad_wdata_q;
  assign row_done       = row_done_q;

endmodule

// File: tb/tb_ifmap_spad_writer.sv
// Self-checking bench for ifmap_spad_writer: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_ifmap_spad_writer;

  localparam int DEPTH = 12;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  fs, isz;
  logic        st, clr, rel;
  logic        spad_wen;
  logic [15:0] spad_waddr;
  logic [15:0] spad_wdata;
  logic [3:0]  count;
  logic        window_ready, full, row_done;
`ifdef IFMAP_SPAD_WR_CHECK_EN
  logic        err;
`endif

  ifmap_spad_writer_if #(.DATA_WIDTH(16)) s_if ();

  ifmap_spad_writer dut (
    .clk          (clk),
    .rstn         (rstn),
    .filter_size  (fs),
    .ifmap_size   (isz),
    .start        (st),
    .if_clear     (clr),
    .in_if        (s_if),
    .rd_release   (rel),
    .spad_wen     (spad_wen),
    .spad_waddr   (spad_waddr),
    .spad_wdata   (spad_wdata),
    .count        (count),
    .window_ready (window_ready),
    .full         (full),
    .row_done     (row_done)
`ifdef IFMAP_SPAD_WR_CHECK_EN
    ,
    .err          (err)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;

  // Model: row progress as two flags, occupancy/pointer as plain integers.
  bit m_filling, m_draining;
  int m_count, m_wptr, m_written, m_fs, m_isz;
  bit e_wen, e_row_done, e_err;
  int e_addr, e_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic model_reset();
    m_filling = 0; m_draining = 0;
    m_count = 0; m_wptr = 0; m_written = 0; m_fs = 0; m_isz = 0;
    e_wen = 0; e_row_done = 0; e_err = 0; e_addr = 0; e_data = 0;
  endtask

  // One clock: check in_ready mid-cycle, advance the model, check outputs after the edge.
  task automatic tick();
    bit m_rdy, acc, freed;
    int old_cnt;
    @(negedge clk);
    m_rdy = m_filling && (m_count < DEPTH) && !clr;
    check("in_ready", 32'(s_if.in_ready), 32'(m_rdy));
    acc = s_if.in_valid && m_rdy;
    old_cnt = m_count;
    e_wen = acc;
    e_row_done = 0;
    if (acc) begin
      e_addr = m_wptr;
      e_data = int'(s_if.in_data);
    end
    if (clr) begin
      m_count = 0; m_wptr = 0; m_written = 0;
      m_filling = 0; m_draining = 0; e_err = 0;
    end else begin
      if (rel && old_cnt == 0) e_err = 1;
      if (st && (fs == 0 || int'(fs) > DEPTH)) e_err = 1;
      freed = rel && (old_cnt > 0);
      m_count = m_count + int'(acc) - int'(freed);
      if (acc) begin
        m_wptr = (m_wptr + 1) % DEPTH;
        m_written++;
        if (m_written == m_isz) begin
          e_row_done = 1; m_filling = 0; m_draining = 1;
        end
      end else if (m_draining) begin
        if (old_cnt == 0) m_draining = 0;
      end else if (!m_filling && st) begin
        m_fs = int'(fs); m_isz = int'(isz); m_written = 0;
        if (m_isz == 0) begin
          m_draining = 1; e_row_done = 1;
        end else begin
          m_filling = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(m_count));
    check("full", 32'(full), 32'(m_count == DEPTH));
    check("window_ready", 32'(window_ready), 32'(m_count > 0 && m_count >= m_fs));
    check("row_done", 32'(row_done), 32'(e_row_done));
    check("spad_wen", 32'(spad_wen), 32'(e_wen));
    check("spad_waddr", 32'(spad_waddr), 32'(e_addr));
    check("spad_wdata", 32'(spad_wdata), 32'(e_data));
`ifdef IFMAP_SPAD_WR_CHECK_EN
    check("err", 32'(err), 32'(e_err));
`endif
  endtask

  task automatic idle_inputs();
    st = 0; clr = 0; rel = 0; s_if.in_valid = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(s_if.in_ready), 32'd0);
    check({tag, "_spad_wen"}, 32'(spad_wen), 32'd0);
    check({tag, "_spad_waddr"}, 32'(spad_waddr), 32'd0);
    check({tag, "_spad_wdata"}, 32'(spad_wdata), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_window_ready"}, 32'(window_ready), 32'd0);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_row_done"}, 32'(row_done), 32'd0);
  endtask

  initial begin
    rstn = 0; fs = 0; isz = 0; s_if.in_data = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;

    // Row of 5 with filter 3, back-to-back writes.
    fs = 5'd3; isz = 5'd5; st = 1; tick(); st = 0;
    s_if.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      s_if.in_data = 16'($urandom); tick();
    end
    s_if.in_valid = 0; tick();
    check("row5_count", 32'(count), 32'd5);

    // Drain to return to IDLE.
    rel = 1; repeat (5) tick();
    rel = 0; tick();

    // Reset mid-row.
    fs = 5'd3; isz = 5'd8; st = 1; tick(); st = 0;
    s_if.in_valid = 1; s_if.in_data = 16'h1234; tick(); tick();
    s_if.in_valid = 0;
    rstn = 0; #2;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;

    // Fill to full, 13th held, one release, 13th lands at address 0.
    fs = 5'd3; isz = 5'd20; st = 1; tick(); st = 0;
    s_if.in_valid = 1;
    for (int i = 0; i < 13; i++) begin
      s_if.in_data = 16'($urandom); tick();
    end
    check("full_flag", 32'(full), 32'd1);
    rel = 1; tick(); rel = 0;
    tick();
    check("wrap_addr", 32'(spad_waddr), 32'd0);
    s_if.in_valid = 0;
    clr = 1; tick(); clr = 0; tick();

    // Handshake and release together at count 4.
    fs = 5'd2; isz = 5'd10; st = 1; tick(); st = 0;
    s_if.in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      s_if.in_data = 16'($urandom); tick();
    end
    rel = 1; s_if.in_data = 16'hbeef; tick();
    check("hs_rel_count", 32'(count), 32'd4);
    check("hs_rel_addr", 32'(spad_waddr), 32'd4);
    rel = 0; s_if.in_valid = 0;

    // Clear with coincident start and valid.
    st = 1; clr = 1; s_if.in_valid = 1; tick();
    check("clr_wen", 32'(spad_wen), 32'd0);
    check("clr_count", 32'(count), 32'd0);
    st = 0; clr = 0; s_if.in_valid = 0;
    fs = 5'd1; isz = 5'd2; st = 1; tick(); st = 0;
    s_if.in_valid = 1; s_if.in_data = 16'h5a5a; tick();
    check("clr_next_addr", 32'(spad_waddr), 32'd0);
    s_if.in_valid = 0; tick();

`ifdef IFMAP_SPAD_WR_CHECK_EN
    // Release at empty sets a sticky error that only a clear removes.
    clr = 1; tick(); clr = 0;
    rel = 1; tick(); rel = 0;
    check("err_set", 32'(err), 32'd1);
    check("err_count", 32'(count), 32'd0);
    tick(); tick();
    check("err_sticky", 32'(err), 32'd1);
    clr = 1; tick(); clr = 0;
    check("err_clr", 32'(err), 32'd0);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      st = ($urandom % 8) == 0;
      fs = 5'($urandom % 14);
      isz = 5'($urandom % 21);
      clr = ($urandom % 64) == 0;
      s_if.in_valid = ($urandom % 4) != 0;
      rel = ($urandom % 3) == 0;
      s_if.in_data = 16'($urandom);
      tick();
    end
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
